accum_feeder: RTL and testbench
===============================

// Module: accum_feeder
// PURPOSE
//  Transmit side of the accumulator stream interface (VALUE/VALID/TERM in, SUM/DONE back).
//  Takes an 8-bit total and emits it as a burst of non-zero 4-bit chunks, then one TERM pulse.
//  Waits for the accumulator's DONE and checks the returned SUM against the total.
//  Sits between a test/control master and an accumulator instance.
// PARAMETERS
//  MAX_CHUNK  15  largest chunk value emitted per VALID cycle; legal 1..15
//  TIMEOUT    16  cycles to wait in WAIT for I_DONE before flagging O_TIMEOUT; legal >=1
// PORTS
//  clk        in   1  single clock, rising edge
//  rstn       in   1  asynchronous active-low reset
//  I_START    in   1  request: send I_TOTAL; sampled only in IDLE
//  I_TOTAL    in   8  value to transmit, latched on accepted I_START
//  I_DONE     in   1  accumulator done pulse
//  I_SUM      in   8  accumulator sum, sampled when I_DONE=1 in WAIT
//  O_VALUE    out  4  chunk value; non-zero whenever O_VALID=1, else 0
//  O_VALID    out  1  chunk valid
//  O_TERM     out  1  one-cycle terminate pulse
//  O_BUSY     out  1  1 in every state except IDLE
//  O_DONE     out  1  one-cycle result pulse
//  O_MATCH    out  1  valid with O_DONE: captured sum == latched total
//  O_TIMEOUT  out  1  valid with O_DONE: no I_DONE within TIMEOUT cycles
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all outputs 0; remain, total, timer cleared.
//  All outputs are decoded from registered state and datapath, with no input-to-output path.
//  States: IDLE, SEND, TERM, WAIT, REPORT.
//  IDLE: on I_START latch r_total=r_remain=I_TOTAL.
//    If I_TOTAL!=0, go to SEND; else go to TERM. Zero chunks are never sent.
//  SEND: O_VALID=1, O_VALUE=min(r_remain,MAX_CHUNK), r_remain-=O_VALUE each cycle.
//    Go to TERM when r_remain<=MAX_CHUNK, after that last chunk.
//    Chunk count = ceil(total/MAX_CHUNK); chunks are back-to-back with no gaps.
//  TERM: O_TERM=1, O_VALID=0 for exactly one cycle -> WAIT; timer cleared.
//  WAIT: if I_DONE, capture I_SUM and set match=(I_SUM==r_total), timeout=0 -> REPORT.
//    Else timer+1; when timer reaches TIMEOUT, set match=0, timeout=1 -> REPORT.
//    I_DONE on the same cycle the timer expires counts as DONE, with no timeout.
//  REPORT: O_DONE=1 for one cycle with O_MATCH/O_TIMEOUT -> IDLE.
//    O_MATCH and O_TIMEOUT hold until the next accepted I_START.
//  Latency: first O_VALID is in the cycle after I_START is sampled.
//  I_START outside IDLE is ignored and is not queued. I_DONE outside WAIT is ignored.
//  Arithmetic: r_remain is 8-bit unsigned and never underflows (subtract <= remain).
//    Compare is 8-bit, and the accumulator's 8-bit wrap is not modelled.
//  Reset mid-operation: immediate return to IDLE; VALID/TERM drop asynchronously; no DONE.
// STRUCTURE
//  accum_pkg: ACC_VAL_W=4, ACC_SUM_W=8, typedef enum logic[2:0] feeder_state_t
//    {IDLE,SEND,TERM,WAIT,REPORT}; shared by accumulator, feeder and benches.
//  Sub-module accum_wdog: clear/enable timeout counter, width $clog2(TIMEOUT+1), expire flag.
//  Parameter legality is checked with elaboration-time assertions.
// TESTING (bench pairs the feeder with a reference accumulator model unless noted)
//  1 Single chunk: TOTAL=9 -> VALUE 9 x1, TERM.
//    DONE/SUM=9 -> O_DONE, MATCH=1, TIMEOUT=0.
//  2 Multi-chunk: TOTAL=40 -> 15,15,10 then TERM.
//    TOTAL=255 -> 17x15. Both give MATCH=1.
//  3 Zero: TOTAL=0 -> no VALID cycles, TERM at cycle after START, MATCH=1 on SUM=0.
//  4 Mismatch: model answers SUM=39 for TOTAL=40 -> O_DONE with MATCH=0, TIMEOUT=0.
//  5 Timeout: bench never drives I_DONE -> O_DONE TIMEOUT+1 cycles after TERM.
//    Result is TIMEOUT=1, MATCH=0. I_DONE on the expiry cycle gives TIMEOUT=0.
//  6 Robustness: I_START during SEND ignored (chunk sequence unchanged).
//    rstn low mid-SEND -> all outputs 0; next START TOTAL=20 gives 15,5 clean.

Source files
------------

// File: rtl/accum_pkg.sv
// ---------------------------------------------------------------------------
// accum_pkg
//   Definitions shared by the accumulator, the accumulator feeder and their
//   benches: stream widths, the feeder state encoding, the result record and
//   the chunk-size helper.
//   No ports; pull in with "import accum_pkg::*;".
// ---------------------------------------------------------------------------
package accum_pkg;

   // Width of one VALUE chunk on the accumulator stream
   localparam int ACC_VAL_W = 4;
   // Width of the running SUM and of the feeder's total
   localparam int ACC_SUM_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND   = 3'd1,
      TERM   = 3'd2,
      WAIT   = 3'd3,
      REPORT = 3'd4
   } feeder_state_t;

   // Outcome of one transfer as reported alongside O_DONE
   typedef struct packed {
      logic match;
      logic timeout;
   } feeder_result_t;

   // Size of the next chunk: everything that is left, capped at max_chunk.
   // The caller guarantees max_chunk fits in ACC_VAL_W bits, so the
   // truncation below never drops set bits.
   function automatic logic [ACC_VAL_W-1:0] chunk_of(
      input logic [ACC_SUM_W-1:0] remain,
      input logic [ACC_SUM_W-1:0] max_chunk
   );
      logic [ACC_SUM_W-1:0] pick;
      pick = (remain > max_chunk) ? max_chunk : remain;
      return pick[ACC_VAL_W-1:0];
   endfunction

endpackage

// File: rtl/accum_wdog.sv
// ---------------------------------------------------------------------------
// accum_wdog
//   Timeout counter for the feeder's WAIT state. The count is held at zero
//   while clear is high and advances by one per enabled cycle, saturating
//   at TIMEOUT. expire flags the enabled cycle whose increment brings the
//   count to TIMEOUT, so the owner can leave on that very edge.
// Ports
//   clk     in   1  rising-edge clock
//   rstn    in   1  asynchronous active-low reset
//   clear   in   1  synchronous clear of the count (wins over enable)
//   enable  in   1  count this cycle
//   expire  out  1  this enabled cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module accum_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != LIMIT)) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   // The count still reads TIMEOUT-1 during the last waiting cycle.
   assign expire = enable && (count_reg == LAST);

   generate
      if (TIMEOUT < 1) begin : g_bad_timeout
         $error("accum_wdog: TIMEOUT must be at least 1");
      end
   endgenerate

endmodule

// File: rtl/accum_feeder.sv
// ---------------------------------------------------------------------------
// accum_feeder
//   Transmit side of the accumulator stream. A requested 8-bit total is
//   sent as a back-to-back burst of non-zero chunks of at most MAX_CHUNK,
//   followed by a single TERM pulse. The feeder then waits up to TIMEOUT
//   cycles for the accumulator's DONE and reports whether the returned sum
//   equals the total, or that the accumulator never answered.
// Ports
//   clk        in   1  rising-edge clock
//   rstn       in   1  asynchronous active-low reset
//   I_START    in   1  send request, accepted only while idle
//   I_TOTAL    in   8  value to send, latched with an accepted I_START
//   I_DONE     in   1  accumulator done pulse, looked at only while waiting
//   I_SUM      in   8  accumulator sum, sampled together with I_DONE
//   O_VALUE    out  4  chunk value, non-zero with O_VALID, 0 otherwise
//   O_VALID    out  1  chunk valid
//   O_TERM     out  1  one-cycle end-of-burst pulse
//   O_BUSY     out  1  high whenever a transfer is in progress
//   O_DONE     out  1  one-cycle result pulse
//   O_MATCH    out  1  returned sum equalled the total (held until next start)
//   O_TIMEOUT  out  1  no DONE arrived in time (held until next start)
// ---------------------------------------------------------------------------
module accum_feeder
   import accum_pkg::*;
#(
   parameter int MAX_CHUNK = 15,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 I_START,
   input  logic [ACC_SUM_W-1:0] I_TOTAL,
   input  logic                 I_DONE,
   input  logic [ACC_SUM_W-1:0] I_SUM,
   output logic [ACC_VAL_W-1:0] O_VALUE,
   output logic                 O_VALID,
   output logic                 O_TERM,
   output logic                 O_BUSY,
   output logic                 O_DONE,
   output logic                 O_MATCH,
   output logic                 O_TIMEOUT
);

   localparam logic [ACC_SUM_W-1:0] MAX_C = ACC_SUM_W'(MAX_CHUNK);

   // -----------------------------------------------------------------------
   // Parameter legality
   // -----------------------------------------------------------------------
   generate
      if ((MAX_CHUNK < 1) || (MAX_CHUNK > 15)) begin : g_bad_max_chunk
         $error("accum_feeder: MAX_CHUNK must be in 1..15");
      end
      if (MAX_CHUNK >= (1 << ACC_VAL_W)) begin : g_bad_value_width
         $error("accum_feeder: MAX_CHUNK does not fit the VALUE width");
      end
      if (TIMEOUT < 1) begin : g_bad_timeout
         $error("accum_feeder: TIMEOUT must be at least 1");
      end
   endgenerate

   // -----------------------------------------------------------------------
   // State and datapath registers
   // -----------------------------------------------------------------------
   feeder_state_t          state_reg;
   logic [ACC_SUM_W-1:0]   remain_reg;
   logic [ACC_SUM_W-1:0]   total_reg;
   feeder_result_t         result_reg;

   // Every output comes straight from a flop, so nothing on the input side
   // can reach an output within the same cycle.
   logic [ACC_VAL_W-1:0]   value_reg;
   logic                   valid_reg;
   logic                   term_reg;
   logic                   busy_reg;
   logic                   done_reg;

   // -----------------------------------------------------------------------
   // Burst arithmetic
   // -----------------------------------------------------------------------
   logic [ACC_VAL_W-1:0]   chunk_now;
   logic [ACC_SUM_W-1:0]   remain_after;
   logic                   last_chunk;
   logic [ACC_VAL_W-1:0]   chunk_first;
   logic [ACC_VAL_W-1:0]   chunk_following;

   // chunk_now never exceeds remain_reg, so the subtraction cannot wrap.
   assign chunk_now       = chunk_of(remain_reg, MAX_C);
   assign remain_after    = remain_reg - ACC_SUM_W'(chunk_now);
   assign last_chunk      = (remain_reg <= MAX_C);
   assign chunk_first     = chunk_of(I_TOTAL, MAX_C);
   assign chunk_following = chunk_of(remain_after, MAX_C);

   // -----------------------------------------------------------------------
   // Response timer
   // -----------------------------------------------------------------------
   logic wdog_clear;
   logic wdog_enable;
   logic wdog_expire;

   // Held clear outside WAIT, so every wait starts from zero after TERM.
   assign wdog_clear  = (state_reg != WAIT);
   assign wdog_enable = (state_reg == WAIT);

   accum_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (wdog_clear),
      .enable (wdog_enable),
      .expire (wdog_expire)
   );

   // -----------------------------------------------------------------------
   // Control FSM. The output flops are loaded with the values belonging to
   // the state being entered, so they line up with state_reg.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg  <= IDLE;
         remain_reg <= '0;
         total_reg  <= '0;
         result_reg <= '0;
         value_reg  <= '0;
         valid_reg  <= 1'b0;
         term_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         // Pulse-type outputs default low; states raise them as needed.
         value_reg <= '0;
         valid_reg <= 1'b0;
         term_reg  <= 1'b0;
         done_reg  <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (I_START) begin
                  total_reg  <= I_TOTAL;
                  remain_reg <= I_TOTAL;
                  result_reg <= '0;
                  busy_reg   <= 1'b1;
                  if (I_TOTAL != '0) begin
                     state_reg <= SEND;
                     valid_reg <= 1'b1;
                     value_reg <= chunk_first;
                  end else begin
                     // Nothing to send: go straight to the terminator.
                     state_reg <= TERM;
                     term_reg  <= 1'b1;
                  end
               end
            end

            SEND: begin
               remain_reg <= remain_after;
               if (last_chunk) begin
                  state_reg <= TERM;
                  term_reg  <= 1'b1;
               end else begin
                  valid_reg <= 1'b1;
                  value_reg <= chunk_following;
               end
            end

            TERM: begin
               state_reg <= WAIT;
            end

            WAIT: begin
               // A DONE arriving on the expiry cycle takes precedence.
               if (I_DONE) begin
                  result_reg.match   <= (I_SUM == total_reg);
                  result_reg.timeout <= 1'b0;
                  state_reg          <= REPORT;
                  done_reg           <= 1'b1;
               end else if (wdog_expire) begin
                  result_reg.match   <= 1'b0;
                  result_reg.timeout <= 1'b1;
                  state_reg          <= REPORT;
                  done_reg           <= 1'b1;
               end
            end

            REPORT: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign O_VALUE   = value_reg;
   assign O_VALID   = valid_reg;
   assign O_TERM    = term_reg;
   assign O_BUSY    = busy_reg;
   assign O_DONE    = done_reg;
   assign O_MATCH   = result_reg.match;
   assign O_TIMEOUT = result_reg.timeout;

endmodule

// File: tb/tb_accum_feeder.sv
// ---------------------------------------------------------------------------
// tb_accum_feeder
//   Pairs accum_feeder with a behavioural accumulator that sums the chunks,
//   snapshots the sum at TERM and answers DONE after a programmable delay
//   (or never). Expected chunks and results are queued when a transfer is
//   started and popped by a negedge monitor as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_accum_feeder;

   localparam int MAX_CHUNK = 15;
   localparam int TIMEOUT   = 16;

   logic       clk = 1'b0;
   logic       rstn;
   logic       I_START;
   logic [7:0] I_TOTAL;
   logic       I_DONE = 1'b0;
   logic [7:0] I_SUM  = 8'd0;
   logic [3:0] O_VALUE;
   logic       O_VALID;
   logic       O_TERM;
   logic       O_BUSY;
   logic       O_DONE;
   logic       O_MATCH;
   logic       O_TIMEOUT;

   accum_feeder #(
      .MAX_CHUNK (MAX_CHUNK),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .I_START   (I_START),
      .I_TOTAL   (I_TOTAL),
      .I_DONE    (I_DONE),
      .I_SUM     (I_SUM),
      .O_VALUE   (O_VALUE),
      .O_VALID   (O_VALID),
      .O_TERM    (O_TERM),
      .O_BUSY    (O_BUSY),
      .O_DONE    (O_DONE),
      .O_MATCH   (O_MATCH),
      .O_TIMEOUT (O_TIMEOUT)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard queues: chunk values and {match,timeout} results
   int         exp_chunks[$];
   logic [1:0] exp_res[$];

   // Monitor bookkeeping
   int         term_cyc   = 0;
   int         done_cyc   = 0;
   int         done_count = 0;
   int         mon_chunk;
   logic [1:0] mon_res;

   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (O_VALID) begin
            if (exp_chunks.size() > 0) begin
               mon_chunk = exp_chunks.pop_front();
               check("chunk_value", 32'(O_VALUE), 32'(mon_chunk));
            end else begin
               check("extra_chunk", 32'(O_VALID), 32'd0);
            end
         end else begin
            check("value_zero_when_idle", 32'(O_VALUE), 32'd0);
         end
         if (O_TERM) begin
            term_cyc = cyc;
            check("chunks_left_at_term", 32'(exp_chunks.size()), 32'd0);
         end
         if (O_DONE) begin
            done_cyc = cyc;
            done_count++;
            if (exp_res.size() > 0) begin
               mon_res = exp_res.pop_front();
               check("match", 32'(O_MATCH), 32'(mon_res[1]));
               check("timeout", 32'(O_TIMEOUT), 32'(mon_res[0]));
            end else begin
               check("extra_done", 32'(O_DONE), 32'd0);
            end
         end
      end
   end

   // Reference accumulator: delay -1 means it never answers
   int         acc = 0;
   logic [7:0] snap = 8'd0;
   bit         pending = 1'b0;
   int         resp_cnt = 0;
   logic [7:0] model_bias = 8'd0;
   int         model_delay = 0;

   always @(negedge clk) begin
      if (rstn !== 1'b1) begin
         acc     = 0;
         pending = 1'b0;
         I_DONE  = 1'b0;
      end else begin
         I_DONE = 1'b0;
         if (pending) begin
            if (resp_cnt == 0) begin
               I_DONE  = 1'b1;
               I_SUM   = snap;
               pending = 1'b0;
            end else begin
               resp_cnt--;
            end
         end
         if (O_VALID) acc += int'(O_VALUE);
         if (O_TERM) begin
            snap = 8'(acc) + model_bias;
            acc  = 0;
            if (model_delay >= 0) begin
               pending  = 1'b1;
               resp_cnt = model_delay;
            end
         end
      end
   end

   // One complete transfer with scoreboard and timing checks
   task automatic run(input int total, input logic [7:0] bias, input int delay, input bit inject);
      int   t;
      int   n;
      int   c;
      int   start_cyc;
      int   base_done;
      bit   exp_m;
      bit   exp_t;
      t = total;
      n = 0;
      while (t > 0) begin
         c = (t > MAX_CHUNK) ? MAX_CHUNK : t;
         exp_chunks.push_back(c);
         t -= c;
         n++;
      end
      exp_t = (delay < 0);
      exp_m = !exp_t && (bias == 8'd0);
      exp_res.push_back({exp_m, exp_t});
      model_bias  = bias;
      model_delay = delay;
      base_done   = done_count;

      @(negedge clk);
      I_START   = 1'b1;
      I_TOTAL   = 8'(total);
      start_cyc = cyc + 1;
      @(negedge clk);
      I_START = 1'b0;
      check("first_valid_latency", 32'(O_VALID), 32'(n != 0));
      check("zero_term_latency", 32'(O_TERM), 32'(n == 0));
      check("busy_after_start", 32'(O_BUSY), 32'd1);

      if (inject) begin
         repeat (2) @(negedge clk);
         I_START = 1'b1;
         I_TOTAL = 8'd7;
         @(negedge clk);
         I_START = 1'b0;
      end

      for (int i = 0; i < 400; i++) begin
         if (done_count != base_done) break;
         @(negedge clk);
      end
      check("done_seen", 32'(done_count != base_done), 32'd1);
      check("burst_length", 32'(term_cyc - start_cyc), 32'(n));
      check("done_after_term", 32'(done_cyc - term_cyc),
            32'((delay < 0) ? TIMEOUT + 1 : delay + 2));

      repeat (2) @(negedge clk);
      check("busy_idle", 32'(O_BUSY), 32'd0);
      check("done_single_pulse", 32'(O_DONE), 32'd0);
      check("match_held", 32'(O_MATCH), 32'(exp_m));
      check("timeout_held", 32'(O_TIMEOUT), 32'(exp_t));
      $display("transfer total=%0d chunks=%0d delay=%0d match=%0b timeout=%0b",
               total, n, delay, O_MATCH, O_TIMEOUT);
   endtask

   int base_mid;

   initial begin
      rstn    = 1'b0;
      I_START = 1'b0;
      I_TOTAL = 8'd0;
      #3;
      check("rst_value", 32'(O_VALUE), 32'd0);
      check("rst_valid", 32'(O_VALID), 32'd0);
      check("rst_term", 32'(O_TERM), 32'd0);
      check("rst_busy", 32'(O_BUSY), 32'd0);
      check("rst_done", 32'(O_DONE), 32'd0);
      check("rst_match", 32'(O_MATCH), 32'd0);
      check("rst_timeout", 32'(O_TIMEOUT), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      run(9,   8'd0,   2,           1'b0);   // single chunk
      run(40,  8'd0,   1,           1'b0);   // 15,15,10
      run(255, 8'd0,   3,           1'b0);   // 17 x 15
      run(16,  8'd0,   0,           1'b0);   // 15,1
      run(15,  8'd0,   2,           1'b0);   // exactly one full chunk
      run(0,   8'd0,   0,           1'b0);   // zero total
      run(40,  8'hFF,  2,           1'b0);   // accumulator answers 39
      run(33,  8'd0,   -1,          1'b0);   // no answer
      run(15,  8'd0,   TIMEOUT - 1, 1'b0);   // answer on expiry cycle
      run(255, 8'd0,   2,           1'b1);   // stray START during SEND

      // Reset in the middle of a burst
      exp_chunks.push_back(15);
      exp_chunks.push_back(15);
      exp_chunks.push_back(15);
      exp_chunks.push_back(15);
      base_mid = done_count;
      @(negedge clk);
      I_START = 1'b1;
      I_TOTAL = 8'd200;
      @(negedge clk);
      I_START = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_valid", 32'(O_VALID), 32'd0);
      check("midrst_value", 32'(O_VALUE), 32'd0);
      check("midrst_term", 32'(O_TERM), 32'd0);
      check("midrst_busy", 32'(O_BUSY), 32'd0);
      check("midrst_done", 32'(O_DONE), 32'd0);
      check("midrst_match", 32'(O_MATCH), 32'd0);
      exp_chunks.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_no_done", 32'(done_count), 32'(base_mid));
      check("midrst_idle", 32'(O_BUSY), 32'd0);
      $display("mid-burst reset applied and released");

      run(20, 8'd0, 1, 1'b0);                // 15,5 after reset

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
